// File: rtl/bp_resolve_unit.sv
// bp_resolve_unit: queues fetch-time predictions, resolves them at execute, drives predictor update and flush/redirect.
module bp_resolve_unit #(
  parameter int INSTR_SIZE_BYTE = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH = 16,
  localparam int XLEN = INSTR_SIZE_BYTE * 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_fetch_nop,
  input  logic [XLEN-1:0]      in_fetch_pc,
  input  logic                 in_fetch_pred_taken,
  input  logic [XLEN-1:0]      in_fetch_pred_offset,
  input  logic                 in_exe_nop,
  input  logic [XLEN-1:0]      in_exe_pc,
  input  logic                 in_exe_is_branch,
  input  logic                 in_exe_branch_taken,
  input  logic [XLEN-1:0]      in_exe_branch_offset,
  output logic                 out_upd_nop,
  output logic [XLEN-1:0]      out_upd_pc,
  output logic                 out_upd_taken,
  output logic [XLEN-1:0]      out_upd_offset,
  output logic                 out_flush,
  output logic [XLEN-1:0]      out_redirect_pc,
  output logic                 out_fetch_stall,
  output logic                 out_seq_err,
  output logic [CNT_WIDTH-1:0] out_branch_cnt,
  output logic [CNT_WIDTH-1:0] out_mispred_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [XLEN-1:0] q_pc [FIFO_DEPTH];
  logic [XLEN-1:0] q_off [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_pt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic full, empty, pop_req, pop, push, e_pt, tk, mis, upd;
  logic [XLEN-1:0] e_pc, e_off;
  always_comb begin
    full = count == (AW+1)'(FIFO_DEPTH);
    empty = count == '0;
    e_pc = q_pc[rd_ptr];
    e_off = q_off[rd_ptr];
    e_pt = q_pt[rd_ptr];
    pop_req = !in_exe_nop && !out_flush;
    pop = pop_req && !empty;
    tk = in_exe_is_branch && in_exe_branch_taken;
    mis = pop && (in_exe_is_branch ? (e_pt != tk || (tk && e_off != in_exe_branch_offset)) : e_pt);
    upd = pop && (in_exe_is_branch || e_pt);
    // a mispredict this cycle means the concurrent fetch is wrong-path
    push = !in_fetch_nop && !out_flush && (!full || pop) && !mis;
    out_fetch_stall = full;
  end
  always_ff @(posedge clk)
    if (push) begin
      q_pc[wr_ptr] <= in_fetch_pc;
      q_off[wr_ptr] <= in_fetch_pred_offset;
      q_pt[wr_ptr] <= in_fetch_pred_taken;
    end
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_upd_nop <= 1'b1;
      out_upd_pc <= '0;
      out_upd_taken <= 1'b0;
      out_upd_offset <= '0;
      out_flush <= 1'b0;
      out_redirect_pc <= '0;
      out_seq_err <= 1'b0;
      out_branch_cnt <= '0;
      out_mispred_cnt <= '0;
    end else begin
      out_upd_nop <= !upd;
      out_flush <= mis;
      if (upd) begin
        out_upd_pc <= in_exe_pc;
        out_upd_taken <= tk;
        out_upd_offset <= in_exe_is_branch ? in_exe_branch_offset : '0;
      end
      if (mis) out_redirect_pc <= tk ? in_exe_pc + in_exe_branch_offset : in_exe_pc + XLEN'(INSTR_SIZE_BYTE);
      if ((pop_req && empty) || (pop && e_pc != in_exe_pc)) out_seq_err <= 1'b1;
      if (pop && in_exe_is_branch && !(&out_branch_cnt)) out_branch_cnt <= out_branch_cnt + CNT_WIDTH'(1);
      if (mis && !(&out_mispred_cnt)) out_mispred_cnt <= out_mispred_cnt + CNT_WIDTH'(1);
      if (mis) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
endmodule

// File: tb/tb_bp_resolve_unit.sv
// tb_bp_resolve_unit: directed scenario tests; a second instance with 3-bit counters exercises saturation.
module tb_bp_resolve_unit;
  logic clk = 0, rst = 1;
  logic f_nop, f_pt, e_nop, e_br, e_tk;
  logic [31:0] f_pc, f_off, e_pc, e_off;
  logic upd_nop, upd_taken, flush, stall, seq_err;
  logic [31:0] upd_pc, upd_off, redir;
  logic [15:0] bcnt, mcnt;
  logic s_upd_nop, s_upd_taken, s_flush, s_stall, s_seq_err;
  logic [31:0] s_upd_pc, s_upd_off, s_redir;
  logic [2:0] s_bcnt, s_mcnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  bp_resolve_unit dut (.clk(clk), .rst(rst), .in_fetch_nop(f_nop), .in_fetch_pc(f_pc),
    .in_fetch_pred_taken(f_pt), .in_fetch_pred_offset(f_off), .in_exe_nop(e_nop), .in_exe_pc(e_pc),
    .in_exe_is_branch(e_br), .in_exe_branch_taken(e_tk), .in_exe_branch_offset(e_off),
    .out_upd_nop(upd_nop), .out_upd_pc(upd_pc), .out_upd_taken(upd_taken), .out_upd_offset(upd_off),
    .out_flush(flush), .out_redirect_pc(redir), .out_fetch_stall(stall), .out_seq_err(seq_err),
    .out_branch_cnt(bcnt), .out_mispred_cnt(mcnt));
  bp_resolve_unit #(.CNT_WIDTH(3)) dut_s (.clk(clk), .rst(rst), .in_fetch_nop(f_nop), .in_fetch_pc(f_pc),
    .in_fetch_pred_taken(f_pt), .in_fetch_pred_offset(f_off), .in_exe_nop(e_nop), .in_exe_pc(e_pc),
    .in_exe_is_branch(e_br), .in_exe_branch_taken(e_tk), .in_exe_branch_offset(e_off),
    .out_upd_nop(s_upd_nop), .out_upd_pc(s_upd_pc), .out_upd_taken(s_upd_taken), .out_upd_offset(s_upd_off),
    .out_flush(s_flush), .out_redirect_pc(s_redir), .out_fetch_stall(s_stall), .out_seq_err(s_seq_err),
    .out_branch_cnt(s_bcnt), .out_mispred_cnt(s_mcnt));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    f_nop = 1; f_pc = 0; f_pt = 0; f_off = 0;
    e_nop = 1; e_pc = 0; e_br = 0; e_tk = 0; e_off = 0;
  endtask
  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] off);
    f_nop = 0; f_pc = pc; f_pt = pt; f_off = off;
  endtask
  task automatic exe(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] off);
    e_nop = 0; e_pc = pc; e_br = br; e_tk = tk; e_off = off;
  endtask
  task automatic test_reset();
    idle(); rst = 1; step(); step();
    total++; if (upd_nop !== 1'b1) begin $display("FAIL reset_upd_nop got=%b exp=1", upd_nop); bad++; end
    total++; if (flush !== 1'b0) begin $display("FAIL reset_flush got=%b exp=0", flush); bad++; end
    total++; if (stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", stall); bad++; end
    total++; if (seq_err !== 1'b0) begin $display("FAIL reset_seq_err got=%b exp=0", seq_err); bad++; end
    total++; if ({bcnt, mcnt} !== 32'h0) begin $display("FAIL reset_cnts got=%h exp=0", {bcnt, mcnt}); bad++; end
    total++; if ({redir, upd_pc, upd_off} !== 96'h0) begin $display("FAIL reset_regs got=%h exp=0", {redir, upd_pc, upd_off}); bad++; end
    rst = 0;
  endtask
  task automatic test_correct_predict();
    idle(); fetch(32'h100, 1, 32'h40); step();
    idle(); exe(32'h100, 1, 1, 32'h40); step();
    total++; if ({upd_nop, upd_taken, flush} !== 3'b010) begin $display("FAIL cp_flags got=%b exp=010", {upd_nop, upd_taken, flush}); bad++; end
    total++; if (upd_off !== 32'h40 || upd_pc !== 32'h100) begin $display("FAIL cp_upd got=%h/%h exp=100/40", upd_pc, upd_off); bad++; end
    total++; if (bcnt !== 16'd1 || mcnt !== 16'd0) begin $display("FAIL cp_cnt got=%0d/%0d exp=1/0", bcnt, mcnt); bad++; end
    idle(); step();
    total++; if (upd_nop !== 1'b1) begin $display("FAIL cp_idle_upd_nop got=%b exp=1", upd_nop); bad++; end
  endtask
  task automatic test_mispredict();
    idle(); fetch(32'h200, 0, 32'h0); step();
    idle(); exe(32'h200, 1, 1, 32'h20); fetch(32'h999, 0, 32'h0); step();
    total++; if (flush !== 1'b1 || redir !== 32'h220) begin $display("FAIL mp_flush got=%b/%h exp=1/220", flush, redir); bad++; end
    total++; if (mcnt !== 16'd1 || bcnt !== 16'd2) begin $display("FAIL mp_cnt got=%0d/%0d exp=2/1", bcnt, mcnt); bad++; end
    total++; if (upd_nop !== 1'b0 || upd_taken !== 1'b1 || upd_off !== 32'h20) begin $display("FAIL mp_upd got=%b/%b/%h exp=0/1/20", upd_nop, upd_taken, upd_off); bad++; end
    idle(); exe(32'h999, 1, 1, 32'h4); fetch(32'h777, 1, 32'h8); step();
    total++; if (flush !== 1'b0 || upd_nop !== 1'b1) begin $display("FAIL mp_pulse got=%b/%b exp=0/1", flush, upd_nop); bad++; end
    total++; if (seq_err !== 1'b0 || bcnt !== 16'd2) begin $display("FAIL mp_ignored got=%b/%0d exp=0/2", seq_err, bcnt); bad++; end
  endtask
  task automatic test_nonbranch();
    idle(); fetch(32'h300, 1, 32'h10); step();
    idle(); exe(32'h300, 0, 0, 32'h0); step();
    total++; if (flush !== 1'b1 || redir !== 32'h304) begin $display("FAIL nb_flush got=%b/%h exp=1/304", flush, redir); bad++; end
    total++; if ({upd_nop, upd_taken} !== 2'b00 || upd_off !== 32'h0 || upd_pc !== 32'h300) begin $display("FAIL nb_upd got=%b%b/%h/%h exp=00/0/300", upd_nop, upd_taken, upd_off, upd_pc); bad++; end
    total++; if (mcnt !== 16'd2 || bcnt !== 16'd2) begin $display("FAIL nb_cnt got=%0d/%0d exp=2/2", bcnt, mcnt); bad++; end
    idle(); step();
  endtask
  task automatic test_full_fifo();
    for (int i = 0; i < 8; i++) begin
      idle(); fetch(32'h1000 + 4 * i, 0, 32'h0); step();
      if (i == 6) begin total++; if (stall !== 1'b0) begin $display("FAIL ff_stall7 got=%b exp=0", stall); bad++; end end
    end
    total++; if (stall !== 1'b1) begin $display("FAIL ff_stall8 got=%b exp=1", stall); bad++; end
    idle(); fetch(32'hBAD, 1, 32'h0); step();
    total++; if (stall !== 1'b1) begin $display("FAIL ff_drop_stall got=%b exp=1", stall); bad++; end
    idle(); fetch(32'h1020, 0, 32'h0); exe(32'h1000, 0, 0, 32'h0); step();
    total++; if (stall !== 1'b1 || upd_nop !== 1'b1 || flush !== 1'b0) begin $display("FAIL ff_pushpop got=%b/%b/%b exp=1/1/0", stall, upd_nop, flush); bad++; end
    for (int i = 1; i <= 8; i++) begin
      idle(); exe(32'h1000 + 4 * i, 0, 0, 32'h0); step();
      if (i == 1) begin total++; if (stall !== 1'b0) begin $display("FAIL ff_unstall got=%b exp=0", stall); bad++; end end
    end
    total++; if (seq_err !== 1'b0) begin $display("FAIL ff_order got=%b exp=0", seq_err); bad++; end
    idle(); step();
  endtask
  task automatic test_seq_err();
    idle(); exe(32'h400, 0, 0, 32'h0); step();
    total++; if (seq_err !== 1'b1 || upd_nop !== 1'b1 || flush !== 1'b0) begin $display("FAIL se_empty got=%b/%b/%b exp=1/1/0", seq_err, upd_nop, flush); bad++; end
    total++; if (bcnt !== 16'd2) begin $display("FAIL se_empty_cnt got=%0d exp=2", bcnt); bad++; end
    idle(); step();
    total++; if (seq_err !== 1'b1) begin $display("FAIL se_sticky got=%b exp=1", seq_err); bad++; end
    rst = 1; step(); rst = 0;
    fetch(32'h504, 0, 32'h0); step();
    idle(); exe(32'h500, 1, 0, 32'h0); step();
    total++; if (seq_err !== 1'b1) begin $display("FAIL se_pc got=%b exp=1", seq_err); bad++; end
    total++; if (upd_nop !== 1'b0 || upd_pc !== 32'h500 || flush !== 1'b0 || bcnt !== 16'd1) begin $display("FAIL se_pc_upd got=%b/%h/%b/%0d exp=0/500/0/1", upd_nop, upd_pc, flush, bcnt); bad++; end
    idle(); step();
  endtask
  task automatic test_wrap_and_sat();
    fetch(32'hFFFFFFF0, 0, 32'h0); step();
    idle(); exe(32'hFFFFFFF0, 1, 1, 32'h20); step();
    total++; if (flush !== 1'b1 || redir !== 32'h10) begin $display("FAIL wrap_redir got=%b/%h exp=1/10", flush, redir); bad++; end
    idle(); step();
    for (int i = 0; i < 8; i++) begin
      fetch(32'h600 + 16 * i, 0, 32'h0); step();
      idle(); exe(32'h600 + 16 * i, 1, 1, 32'h8); step();
      total++; if (flush !== 1'b1 || redir !== 32'h608 + 16 * i) begin $display("FAIL sat_redir%0d got=%b/%h exp=1/%h", i, flush, redir, 32'h608 + 16 * i); bad++; end
      idle(); step();
    end
    total++; if (bcnt !== 16'd10 || mcnt !== 16'd9) begin $display("FAIL sat_main got=%0d/%0d exp=10/9", bcnt, mcnt); bad++; end
    total++; if (s_bcnt !== 3'd7 || s_mcnt !== 3'd7) begin $display("FAIL sat_small got=%0d/%0d exp=7/7", s_bcnt, s_mcnt); bad++; end
  endtask
  task automatic test_reset_mid();
    fetch(32'h700, 1, 32'h0); step();
    fetch(32'h704, 0, 32'h0); step();
    idle(); exe(32'h700, 0, 0, 32'h0); rst = 1; step(); rst = 0;
    total++; if (flush !== 1'b0 || upd_nop !== 1'b1 || redir !== 32'h0) begin $display("FAIL rm_out got=%b/%b/%h exp=0/1/0", flush, upd_nop, redir); bad++; end
    total++; if ({bcnt, mcnt} !== 32'h0 || seq_err !== 1'b0 || stall !== 1'b0) begin $display("FAIL rm_state got=%h/%b/%b exp=0/0/0", {bcnt, mcnt}, seq_err, stall); bad++; end
    idle(); exe(32'h704, 0, 0, 32'h0); step();
    total++; if (seq_err !== 1'b1) begin $display("FAIL rm_discard got=%b exp=1", seq_err); bad++; end
    idle(); step();
  endtask
  initial begin
    idle();
    test_reset();
    test_correct_predict();
    test_mispredict();
    test_nonbranch();
    test_full_fifo();
    test_seq_err();
    test_wrap_and_sat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
